// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: state encoding, default
// timing constants and a small constant-evaluation helper.
package pulse_stretcher_pkg;

    // Two-bit state encoding; code 2'b11 is illegal and recovers to idle.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHigh = 2'b01,
        StGap  = 2'b10
    } ps_state_t;

    localparam int unsigned DEFAULT_HOLD_CYCLES = 4;
    localparam int unsigned DEFAULT_GAP_CYCLES  = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns one-cycle strobes into fixed-length level pulses
// separated by a guaranteed low gap, queueing at most one trigger.
// Optional macro RETRIG_EXTEND_EN: a trigger during the high phase reloads
// the hold counter (retriggerable one-shot) instead of queueing.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic level,
    output logic busy,
    output logic dropped
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    ps_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_level;
    logic             r_busy;
    logic             r_dropped;

    ps_state_t        w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_pending_d;
    logic             w_dropped_d;

    // Next-state, counter, one-deep trigger queue and drop decode.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_pending_d = r_pending;
        w_dropped_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (pulse) begin
                    w_state_d = StHigh;
                    w_cnt_d   = HOLD_LOAD;
                end
            end
            StHigh: begin
                if (r_cnt == '0) begin
                    w_state_d = StGap;
                    w_cnt_d   = GAP_LOAD;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
`ifdef RETRIG_EXTEND_EN
                // Retrigger overrides the exit to the gap, even on the last cycle.
                if (pulse) begin
                    w_state_d = StHigh;
                    w_cnt_d   = HOLD_LOAD;
                end
`else
                if (pulse) begin
                    if (!r_pending) begin
                        w_pending_d = 1'b1;
                    end else begin
                        w_dropped_d = 1'b1;
                    end
                end
`endif
            end
            StGap: begin
                if (r_cnt == '0) begin
                    if (r_pending || pulse) begin
                        w_state_d   = StHigh;
                        w_cnt_d     = HOLD_LOAD;
                        // A queued trigger is consumed first; a coincident pulse re-queues.
                        w_pending_d = r_pending && pulse;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                    if (pulse) begin
                        if (!r_pending) begin
                            w_pending_d = 1'b1;
                        end else begin
                            w_dropped_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_cnt_d     = '0;
                w_pending_d = 1'b0;
            end
        endcase
    end

    // State register; outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_level   <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_pending <= w_pending_d;
            r_level   <= (w_state_d == StHigh);
            r_busy    <= (w_state_d != StIdle) || w_pending_d;
            r_dropped <= w_dropped_d;
        end
    end

    assign level   = r_level;
    assign busy    = r_busy;
    assign dropped = r_dropped;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HOLD_CYCLES=4, GAP_CYCLES=1).
// Cycle c is the interval after the c-th rising edge following reset release;
// a pulse driven in cycle c is sampled at edge c+1. Bit c of each mask gives
// the stimulus or expected output for cycle c.
module tb_pulse_stretcher;

    logic clk = 1'b0;
    logic rst;
    logic pulse;
    logic level;
    logic busy;
    logic dropped;

    int n_checks = 0;
    int n_errors = 0;

    pulse_stretcher dut (
        .clk     (clk),
        .rst     (rst),
        .pulse   (pulse),
        .level   (level),
        .busy    (busy),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        pulse = 1'b0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        pulse = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({level, busy, dropped} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state: got l/b/d=%b required 000", {level, busy, dropped});
        end
        // Pulses at 5 and 6 (second one queues or retriggers), reset in cycle 7.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            pulse = (c == 5 || c == 6);
        end
        n_checks++;
        if (level !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_pre_high: level=%b required 1", level);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({level, busy, dropped} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_async: got l/b/d=%b required 000", {level, busy, dropped});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_residual cyc %0d: got l/b/d=%b required 000", c,
                         {level, busy, dropped});
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] p, l, b, d;
        p = 32'h0000_0020;
        l = 32'h0000_03C0;
        b = 32'h0000_07C0;
        d = 32'h0000_0000;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== {l[c], b[c], d[c]}) begin
                n_errors++;
                $display("FAIL single cyc %0d: got l/b/d=%b required %b", c,
                         {level, busy, dropped}, {l[c], b[c], d[c]});
            end
            pulse = p[c];
        end
    endtask

    task automatic test_gap_pulse();
        logic [31:0] p, l, b, d;
        p = 32'h0000_0420;
        l = 32'h0000_7BC0;
        b = 32'h0000_FFC0;
        d = 32'h0000_0000;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== {l[c], b[c], d[c]}) begin
                n_errors++;
                $display("FAIL gap_pulse cyc %0d: got l/b/d=%b required %b", c,
                         {level, busy, dropped}, {l[c], b[c], d[c]});
            end
            pulse = p[c];
        end
    endtask

`ifdef RETRIG_EXTEND_EN
    task automatic test_retrig();
        logic [31:0] p, l, b, d;
        p = 32'h0000_02A0;
        l = 32'h0000_3FC0;
        b = 32'h0000_7FC0;
        d = 32'h0000_0000;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== {l[c], b[c], d[c]}) begin
                n_errors++;
                $display("FAIL retrig cyc %0d: got l/b/d=%b required %b", c,
                         {level, busy, dropped}, {l[c], b[c], d[c]});
            end
            pulse = p[c];
        end
    endtask
`else
    task automatic test_queue();
        logic [31:0] p, l, b, d;
        p = 32'h0000_00A0;
        l = 32'h0000_7BC0;
        b = 32'h0000_FFC0;
        d = 32'h0000_0000;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== {l[c], b[c], d[c]}) begin
                n_errors++;
                $display("FAIL queue cyc %0d: got l/b/d=%b required %b", c,
                         {level, busy, dropped}, {l[c], b[c], d[c]});
            end
            pulse = p[c];
        end
    endtask

    task automatic test_drop();
        logic [31:0] p, l, b, d;
        p = 32'h0000_01A0;
        l = 32'h0000_7BC0;
        b = 32'h0000_FFC0;
        d = 32'h0000_0200;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== {l[c], b[c], d[c]}) begin
                n_errors++;
                $display("FAIL drop cyc %0d: got l/b/d=%b required %b", c,
                         {level, busy, dropped}, {l[c], b[c], d[c]});
            end
            pulse = p[c];
        end
    endtask

    // Pulse held for cycles 5..15: 4-high/1-low pattern, drops while queue full.
    task automatic test_back_to_back();
        logic [31:0] p, l, b, d;
        p = 32'h0000_FFE0;
        l = 32'h01EF_7BC0;
        b = 32'h03FF_FFC0;
        d = 32'h0000_F700;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level, busy, dropped} !== {l[c], b[c], d[c]}) begin
                n_errors++;
                $display("FAIL back_to_back cyc %0d: got l/b/d=%b required %b", c,
                         {level, busy, dropped}, {l[c], b[c], d[c]});
            end
            pulse = p[c];
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_gap_pulse();
`ifdef RETRIG_EXTEND_EN
        test_retrig();
`else
        test_queue();
        test_drop();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
